// File: rtl/fetch_pc_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_unit_pkg
// Description : Shared constants for the fetch PC stage: FSM state
//               encodings, PC increment, default reset PC and a word-align
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pc_unit_pkg;

    localparam int STATE_WIDTH = 2;

    localparam logic [STATE_WIDTH-1:0] STATE_BOOT  = 2'd0;
    localparam logic [STATE_WIDTH-1:0] STATE_RUN   = 2'd1;
    localparam logic [STATE_WIDTH-1:0] STATE_FLUSH = 2'd2;

    localparam logic [31:0] PC_INCREMENT     = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Instructions are word-aligned; low two address bits are always dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc_unit_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_unit_sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
//               Asynchronous active-low clear.
// Ports       : clock  - rising-edge clock
//               reset  - asynchronous active-low clear
//               enable - count this edge
//               count  - current count value
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_unit_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] C_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (enable && (r_count != C_MAX)) begin
            r_count <= r_count + C_ONE;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_unit
// Description : Program counter and fetch sequencing in front of a
//               synchronous instruction memory. Owns the byte PC, drives the
//               memory word index, tracks which PC the memory output belongs
//               to, marks that output valid/stale across reset and redirects,
//               and keeps fetch statistics.
// Ports       : clock              - rising-edge clock
//               reset              - asynchronous active-low reset
//               stall              - hold the PC this cycle
//               redirectValid      - branch taken / jump this cycle
//               redirectTarget     - byte target of the redirect
//               instructionAddress - word index {2'b00, pc[31:2]}
//               pc                 - current issue PC
//               fetchPc            - PC of the instruction the memory presents
//               fetchValid         - memory output is a wanted instruction
//               fetchState         - FSM state (debug)
//               misalignedTarget   - pulse: last redirect target not 4-aligned
//               fetchCount         - instructions accepted downstream (wraps)
//               redirectCount      - redirects taken (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
    parameter int          MEM_INDEX_WIDTH = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirectValid,
    input  logic [31:0] redirectTarget,
    output logic [31:0] instructionAddress,
    output logic [31:0] pc,
    output logic [31:0] fetchPc,
    output logic        fetchValid,
    output logic [1:0]  fetchState,
    output logic        misalignedTarget,
    output logic [31:0] fetchCount,
    output logic [15:0] redirectCount
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("fetch_pc_unit: RESET_PC must be 4-aligned");
    end

    // The memory wraps its own index; the width only needs to fit in pc[31:2].
    if ((MEM_INDEX_WIDTH < 1) || (MEM_INDEX_WIDTH > 30)) begin : g_bad_index_width
        $error("fetch_pc_unit: MEM_INDEX_WIDTH out of range");
    end

    logic [STATE_WIDTH-1:0] r_state;
    logic [STATE_WIDTH-1:0] w_state_next;
    logic                   w_fetch_valid;

    logic [31:0] r_pc;
    logic [31:0] r_fetch_pc;
    logic        r_misaligned;
    logic [31:0] r_fetch_count;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= STATE_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. Any redirect lands in FLUSH because the word the
    // memory latches on that edge belongs to the abandoned path. Stall
    // does not hold FLUSH: the memory re-reads the redirected pc, which is
    // exactly the wanted instruction.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            STATE_BOOT:  w_state_next = redirectValid ? STATE_FLUSH : STATE_RUN;
            STATE_RUN:   w_state_next = redirectValid ? STATE_FLUSH : STATE_RUN;
            STATE_FLUSH: w_state_next = redirectValid ? STATE_FLUSH : STATE_RUN;
            default:     w_state_next = STATE_FLUSH;  // illegal encoding recovers
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_fetch_valid = 1'b0;
        if (r_state == STATE_RUN) begin
            w_fetch_valid = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // PC, fetch PC, misalignment flag and accepted-instruction count
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc          <= RESET_PC;
            r_fetch_pc    <= RESET_PC;
            r_misaligned  <= 1'b0;
            r_fetch_count <= 32'd0;
        end else begin
            if (redirectValid) begin
                r_pc <= align_word(redirectTarget);
            end else if (!stall) begin
                r_pc <= r_pc + PC_INCREMENT;
            end

            // The memory latches the address derived from r_pc on this same
            // edge, so the old r_pc names the word it will present.
            r_fetch_pc   <= r_pc;
            r_misaligned <= redirectValid && (redirectTarget[1:0] != 2'b00);

            if (w_fetch_valid && !stall) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    fetch_pc_unit_sat_counter #(
        .WIDTH (16)
    ) u_redirect_counter (
        .clock  (clock),
        .reset  (reset),
        .enable (redirectValid),
        .count  (redirectCount)
    );

    assign instructionAddress = {2'b00, r_pc[31:2]};
    assign pc                 = r_pc;
    assign fetchPc            = r_fetch_pc;
    assign fetchValid         = w_fetch_valid;
    assign fetchState         = r_state;
    assign misalignedTarget   = r_misaligned;
    assign fetchCount         = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_unit
// Description : Directed self-checking bench for fetch_pc_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        redirectValid;
    logic [31:0] redirectTarget;
    logic [31:0] instructionAddress;
    logic [31:0] pc;
    logic [31:0] fetchPc;
    logic        fetchValid;
    logic [1:0]  fetchState;
    logic        misalignedTarget;
    logic [31:0] fetchCount;
    logic [15:0] redirectCount;

    int tests_run    = 0;
    int tests_failed = 0;

    fetch_pc_unit #(
        .RESET_PC        (32'h0000_0000),
        .MEM_INDEX_WIDTH (10)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .stall              (stall),
        .redirectValid      (redirectValid),
        .redirectTarget     (redirectTarget),
        .instructionAddress (instructionAddress),
        .pc                 (pc),
        .fetchPc            (fetchPc),
        .fetchValid         (fetchValid),
        .fetchState         (fetchState),
        .misalignedTarget   (misalignedTarget),
        .fetchCount         (fetchCount),
        .redirectCount      (redirectCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".pc"},        pc,                       32'h0);
        check({tag, ".fetchPc"},   fetchPc,                  32'h0);
        check({tag, ".addr"},      instructionAddress,       32'h0);
        check({tag, ".valid"},     {31'd0, fetchValid},      32'h0);
        check({tag, ".state"},     {30'd0, fetchState},      32'h0);
        check({tag, ".misalign"},  {31'd0, misalignedTarget}, 32'h0);
        check({tag, ".fcount"},    fetchCount,               32'h0);
        check({tag, ".rcount"},    {16'd0, redirectCount},   32'h0);
    endtask

    initial begin
        reset          = 1'b0;
        stall          = 1'b0;
        redirectValid  = 1'b0;
        redirectTarget = 32'h0;

        // Reset held across a couple of edges
        repeat (2) @(posedge clock);
        #1;
        check_reset_values("rst");
        reset = 1'b1;

        // Edge 1: first valid instruction
        step();
        check("e1.fetchPc", fetchPc,                  32'h0);
        check("e1.valid",   {31'd0, fetchValid},      32'h1);
        check("e1.pc",      pc,                       32'h4);
        check("e1.addr",    instructionAddress,       32'h1);
        check("e1.fcount",  fetchCount,               32'h0);

        repeat (3) step();
        check("e4.pc",      pc,                       32'h10);
        check("e4.fcount",  fetchCount,               32'h3);

        // Edge 5: redirect to 0x100 from pc=0x10
        redirectValid  = 1'b1;
        redirectTarget = 32'h100;
        step();
        redirectValid  = 1'b0;
        check("e5.fcount",  fetchCount,               32'h4);
        check("e5.valid",   {31'd0, fetchValid},      32'h0);
        check("e5.state",   {30'd0, fetchState},      32'h2);
        check("e5.pc",      pc,                       32'h100);
        check("e5.rcount",  {16'd0, redirectCount},   32'h1);

        step();  // edge 6
        check("e6.fetchPc", fetchPc,                  32'h100);
        check("e6.valid",   {31'd0, fetchValid},      32'h1);
        check("e6.pc",      pc,                       32'h104);
        check("e6.fcount",  fetchCount,               32'h4);

        step();  // edge 7
        check("e7.fcount",  fetchCount,               32'h5);

        // Edge 8: redirect and stall together, misaligned target
        redirectValid  = 1'b1;
        redirectTarget = 32'h203;
        stall          = 1'b1;
        step();
        redirectValid  = 1'b0;
        check("e8.pc",       pc,                      32'h200);
        check("e8.misalign", {31'd0, misalignedTarget}, 32'h1);
        check("e8.valid",    {31'd0, fetchValid},     32'h0);
        check("e8.rcount",   {16'd0, redirectCount},  32'h2);
        check("e8.fcount",   fetchCount,              32'h5);

        step();  // edge 9, still stalled: FLUSH -> RUN regardless
        check("e9.misalign", {31'd0, misalignedTarget}, 32'h0);
        check("e9.pc",       pc,                      32'h200);
        check("e9.fetchPc",  fetchPc,                 32'h200);
        check("e9.valid",    {31'd0, fetchValid},     32'h1);
        check("e9.fcount",   fetchCount,              32'h5);

        step();  // edge 10, stalled in RUN
        check("e10.fcount",  fetchCount,              32'h5);
        check("e10.pc",      pc,                      32'h200);
        stall = 1'b0;

        step();  // edge 11
        check("e11.fcount",  fetchCount,              32'h6);
        check("e11.pc",      pc,                      32'h204);

        // Edge 12: redirect to 0x3C so pc reaches 0x40 in RUN
        redirectValid  = 1'b1;
        redirectTarget = 32'h3C;
        step();
        redirectValid  = 1'b0;
        check("e12.fcount",  fetchCount,              32'h7);
        step();  // edge 13
        check("e13.pc",      pc,                      32'h40);
        check("e13.valid",   {31'd0, fetchValid},     32'h1);

        // Stall for 3 cycles at pc=0x40
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall.pc",      pc,                  32'h40);
            check("stall.fetchPc", fetchPc,             32'h40);
            check("stall.addr",    instructionAddress,  32'h10);
            check("stall.valid",   {31'd0, fetchValid}, 32'h1);
            check("stall.fcount",  fetchCount,          32'h7);
        end
        stall = 1'b0;
        step();  // edge 17
        check("e17.fcount",  fetchCount,              32'h8);
        check("e17.pc",      pc,                      32'h44);
        step();  // edge 18
        check("e18.fcount",  fetchCount,              32'h9);

        // PC wrap
        redirectValid  = 1'b1;
        redirectTarget = 32'hFFFF_FFFC;
        step();  // edge 19
        redirectValid  = 1'b0;
        check("e19.pc",      pc,                      32'hFFFF_FFFC);
        check("e19.addr",    instructionAddress,      32'h3FFF_FFFF);
        check("e19.fcount",  fetchCount,              32'hA);
        step();  // edge 20
        check("wrap.pc",      pc,                     32'h0);
        check("wrap.fetchPc", fetchPc,                32'hFFFF_FFFC);
        check("wrap.addr",    instructionAddress,     32'h0);
        step();  // edge 21
        check("e21.fcount",  fetchCount,              32'hB);

        // Address beyond memory size: index 0x400 (memory index 0)
        redirectValid  = 1'b1;
        redirectTarget = 32'h1000;
        step();  // edge 22
        check("e22.addr",    instructionAddress,      32'h400);
        check("e22.rcount",  {16'd0, redirectCount},  32'h5);
        check("e22.fcount",  fetchCount,              32'hC);

        // Saturation: redirects back to back, misaligned target
        redirectTarget = 32'h501;
        for (int i = 0; i < 65529; i++) begin
            step();
        end
        check("sat.almost",  {16'd0, redirectCount},  32'hFFFE);
        for (int i = 0; i < 11; i++) begin
            step();
        end
        check("sat.hold",    {16'd0, redirectCount},  32'hFFFF);
        check("sat.state",   {30'd0, fetchState},     32'h2);
        check("sat.valid",   {31'd0, fetchValid},     32'h0);
        check("sat.pc",      pc,                      32'h500);
        check("sat.misalign", {31'd0, misalignedTarget}, 32'h1);
        check("sat.fcount",  fetchCount,              32'hC);

        // Asynchronous reset mid-cycle, no clock edge in between
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("arst");
        redirectValid = 1'b0;
        #1;
        reset = 1'b1;

        step();
        check("rel.valid",   {31'd0, fetchValid},     32'h1);
        check("rel.pc",      pc,                      32'h4);
        check("rel.fetchPc", fetchPc,                 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter and fetch-sequencing stage directly upstream of the synchronous instruction memory. It owns the byte PC, drives the memory's word-index address, and tracks which PC the memory's registered output currently corresponds to. It also marks that output valid or stale after reset and after branch/jump redirects, and keeps fetch statistics. Its outputs, together with the memory's instruction word, feed the IF/ID pipeline register.

## Interface
- RESET_PC, 32'h0000_0000: byte PC loaded on reset; must be 4-aligned.
- MEM_INDEX_WIDTH, 10: instruction-memory index width; the word index wraps every 2^MEM_INDEX_WIDTH words.

- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hazard unit: hold the PC this cycle.
- redirectValid  in  1  execute stage: branch taken or jump this cycle.
- redirectTarget  in  32  byte target of the redirect.
- instructionAddress  out  32  word index to instruction memory: {2'b00, pc[31:2]}, combinational from pc.
- pc  out  32  current issue PC (byte address).
- fetchPc  out  32  byte PC of the instruction now presented by the memory.
- fetchValid  out  1  memory output is a wanted instruction.
- fetchState  out  2  FSM state, for debug.
- misalignedTarget  out  1  one-cycle pulse: the last redirect target had nonzero [1:0].
- fetchCount  out  32  instructions accepted downstream (wraps).
- redirectCount  out  16  redirects taken (saturating).

## Operation
- **PC update, per edge, in priority order:**
  - redirectValid: pc <= {redirectTarget[31:2], 2'b00}.
  - else stall: pc holds.
  - else pc <= pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- **fetchPc:** fetchPc <= pc on every edge, so it tracks the PC the memory latched on that same edge. Under stall the memory re-reads the held address, so fetchPc and the instruction word are both stable.
- **FSM states:** BOOT=2'd0, RUN=2'd1, FLUSH=2'd2.
  - BOOT: reset state. Next edge goes to FLUSH if redirectValid, else RUN.
  - RUN: next edge goes to FLUSH if redirectValid, else stays RUN.
  - FLUSH: next edge goes to FLUSH if redirectValid, else RUN.
  - Stall never blocks the FLUSH→RUN transition: the memory re-reads the already-redirected pc.
  - fetchValid = (state == RUN), decoded from the state register.
- **misalignedTarget:** registered <= redirectValid && (redirectTarget[1:0] != 0). The target is still force-aligned.
- **fetchCount:** increments on an edge where fetchValid && !stall; 32-bit wrap.
- **redirectCount:** increments on an edge where redirectValid; saturates at 16'hFFFF.
- Encoding 2'd3 is illegal. It recovers to FLUSH on the next edge with fetchValid=0.

## Timing
- **Reset** (asynchronous assert, synchronous-edge effect on release):
  - pc = fetchPc = RESET_PC
  - state = BOOT, fetchValid = 0
  - misalignedTarget = 0
  - fetchCount = 0, redirectCount = 0
  - instructionAddress = RESET_PC >> 2
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.
- **Latency:**
  - instructionAddress follows pc combinationally.
  - The instruction for a PC appears one cycle after that PC is issued, alongside fetchPc and fetchValid.
  - First valid instruction: the first edge after reset release.
- **Redirect penalty:** exactly one invalid cycle, namely the instruction fetched on the redirect edge. The target instruction is valid on the following edge.
- **Back-to-back redirects:** each one extends FLUSH by one cycle, and the last target wins.
- **Redirect and stall in the same cycle:** the redirect wins and redirectCount increments.
- **Stall:** fetchValid holds its value and fetchCount does not increment.

## Structure
- Shared header fetchDefines.vh holds:
  - state encodings (BOOT, RUN, FLUSH)
  - PC_INCREMENT = 4
  - the default RESET_PC
- One sub-module is natural: saturatingCounter (parameterised width, enable, asynchronous active-low clear), used for redirectCount.
- Everything else is flat in fetch_pc_unit.

## Test plan
- **Reset release, no stall:**
  - after edge 1: fetchPc=0x0, fetchValid=1, pc=0x4, instructionAddress=1
  - after 5 edges: fetchCount=4
- **Redirect to 0x100 at pc=0x10:**
  - next cycle: fetchValid=0, pc=0x100
  - following cycle: fetchPc=0x100, fetchValid=1
  - redirectCount=1
- **Redirect and stall together, target 0x203:**
  - pc=0x200, misalignedTarget=1 for exactly one cycle
  - fetchCount unchanged during the stall cycles
- **Stall for 3 cycles in RUN at pc=0x40:**
  - pc, fetchPc, instructionAddress and fetchValid stable
  - fetchCount frozen, then resumes incrementing
- **PC wrap and address wrap:**
  - redirect to 0xFFFF_FFFC, then run: pc wraps to 0x0
  - redirect to 0x1000: instructionAddress=0x400 (memory index 0)
- **Saturation and async reset:**
  - 65 540 redirects: redirectCount holds 0xFFFF
  - reset asserted mid-stream without a clock edge: all outputs return to their reset values immediately
